// File: rtl/softmax_int8_if.sv
// Vector handshake bus for softmax_int8: input vector + scales, output probabilities.
interface softmax_int8_if #(
  parameter int unsigned LANES = 32,
  parameter int unsigned DW    = 8
);
  localparam int unsigned VW = LANES * DW;

  logic          data_in_valid;
  logic          data_in_ready;
  logic [VW-1:0] in_data;
  logic [15:0]   in_scale;
  logic [15:0]   out_scale;
  logic [5:0]    S;
  logic          data_out_valid;
  logic          data_out_ready;
  logic [VW-1:0] out_data;

  modport master (
    output data_in_valid, in_data, in_scale, out_scale, S, data_out_ready,
    input  data_in_ready, data_out_valid, out_data
  );

  modport slave (
    input  data_in_valid, in_data, in_scale, out_scale, S, data_out_ready,
    output data_in_ready, data_out_valid, out_data
  );
endinterface

// File: rtl/softmax_int8.sv
// Integer softmax over one int8 vector: max-subtract, base-2 exp, one reciprocal, per-lane scale.
// SOFTMAX_ROUND_EN: when defined the final >>18 rounds half-up, otherwise it truncates.
module softmax_int8 #(
  parameter int unsigned LANES = 32,
  parameter int unsigned DW    = 8
) (
  input logic           clk,
  input logic           rst,
  softmax_int8_if.slave bus
);
  localparam int unsigned VW = LANES * DW;
  localparam int unsigned EW = 17;
  localparam int unsigned ZW = 25;
  localparam int unsigned SW = 22;
  localparam int unsigned RW = 32;
  localparam int unsigned PW = 49;
  localparam int unsigned QW = 65;

  logic          s1_valid;
  logic [VW-1:0] s1_data;
  logic [15:0]   s1_in_scale;
  logic [15:0]   s1_out_scale;
  logic [5:0]    s1_s;

  logic          out_valid;
  logic [VW-1:0] out_q;

  logic          s2_can_load;
  logic          in_ready;
  logic          accept;

  logic signed [DW-1:0] m;
  logic signed [DW-1:0] xi;
  logic signed [DW:0]   d;
  logic [DW:0]          nd;
  logic [ZW-1:0]        z;
  logic [8:0]           k;
  logic [15:0]          f;
  logic [EW-1:0]        e [LANES];
  logic [SW-1:0]        sum;
  logic [RW-1:0]        recip;
  logic [5:0]           sh;
  logic [PW-1:0]        prod;
  logic [PW-1:0]        p;
  logic [QW-1:0]        scaled;
  logic [QW-1:0]        q;
  logic [VW-1:0]        result;

  assign s2_can_load = !out_valid || bus.data_out_ready;
  assign in_ready    = !s1_valid || s2_can_load;
  assign accept      = bus.data_in_valid && in_ready;

  assign bus.data_in_ready  = in_ready;
  assign bus.data_out_valid = out_valid;
  assign bus.out_data       = out_q;

  // Stage 1: capture the vector and its scaling parameters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_data      <= '0;
      s1_in_scale  <= '0;
      s1_out_scale <= '0;
      s1_s         <= '0;
    end else if (in_ready) begin
      s1_valid <= bus.data_in_valid;
      if (accept) begin
        s1_data      <= bus.in_data;
        s1_in_scale  <= bus.in_scale;
        s1_out_scale <= bus.out_scale;
        s1_s         <= bus.S;
      end
    end
  end

  // Stage 2 datapath: exponent per lane, shared reciprocal, per-lane scaling
  always_comb begin
    m      = s1_data[DW-1:0];
    xi     = '0;
    d      = '0;
    nd     = '0;
    z      = '0;
    k      = '0;
    f      = '0;
    sum    = '0;
    recip  = '0;
    sh     = 6'(s1_s - 6'd16);
    prod   = '0;
    p      = '0;
    scaled = '0;
    q      = '0;
    result = '0;
    for (int i = 0; i < LANES; i++) e[i] = '0;

    for (int i = 1; i < LANES; i++) begin
      xi = s1_data[i*DW +: DW];
      if (xi > m) m = xi;
    end

    for (int i = 0; i < LANES; i++) begin
      xi = s1_data[i*DW +: DW];
      d  = (DW+1)'(xi) - (DW+1)'(m);
      nd = -d;
      z  = ZW'(nd) * ZW'(s1_in_scale);
      k  = z[ZW-1:16];
      f  = z[15:0];
      e[i] = (k >= 9'd17) ? '0 : ((EW'(65536) - EW'(f >> 1)) >> k);
      sum  = sum + SW'(e[i]);
    end

    // sum >= 65536 always (the max lane contributes exactly 1.0), so no divide-by-zero
    recip = (RW'(1) << s1_s) / RW'(sum);

    for (int i = 0; i < LANES; i++) begin
      prod   = PW'(e[i]) * PW'(recip);
      p      = prod >> sh;
      scaled = QW'(p) * QW'(s1_out_scale);
`ifdef SOFTMAX_ROUND_EN
      scaled = scaled + QW'(131072);
`else
      scaled = scaled;
`endif
      q = scaled >> 18;
      result[i*DW +: DW] = (q > QW'(127)) ? DW'(127) : q[DW-1:0];
    end
  end

  // Stage 2: output register, held while downstream stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (s2_can_load) begin
      out_valid <= s1_valid;
      if (s1_valid) out_q <= result;
    end
  end
endmodule

// File: tb/tb_softmax_int8.sv
// Directed bench for softmax_int8: hand-computed vectors, backpressure and reset.
module tb_softmax_int8;
  localparam int unsigned LANES = 32;
  localparam int unsigned VW    = 256;

`ifdef SOFTMAX_ROUND_EN
  localparam logic [7:0] EXP_FLAT = 8'd4;
  localparam logic [7:0] EXP_HOT  = 8'd119;
`else
  localparam logic [7:0] EXP_FLAT = 8'd3;
  localparam logic [7:0] EXP_HOT  = 8'd118;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  softmax_int8_if #(.LANES(LANES), .DW(8)) bus ();

  softmax_int8 #(.LANES(LANES), .DW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] fill(input logic [7:0] val);
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*8 +: 8] = val;
    return v;
  endfunction

  // Single vector with downstream ready: accept at edge N, valid after edge N+1
  task automatic run_one(input string tag, input logic [VW-1:0] v, output logic [VW-1:0] res);
    @(negedge clk);
    check({tag, "_in_ready"}, VW'(bus.data_in_ready), VW'(1));
    bus.in_data       = v;
    bus.data_in_valid = 1'b1;
    @(posedge clk);
    #1 bus.data_in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_early"}, VW'(bus.data_out_valid), VW'(0));
    @(negedge clk);
    check({tag, "_valid"}, VW'(bus.data_out_valid), VW'(1));
    res = bus.out_data;
  endtask

  logic [VW-1:0] v_flat, v_hot, v_two, v_pair;
  logic [VW-1:0] x_flat, x_hot, x_two, x_pair;
  logic [VW-1:0] res;

  initial begin
    checks   = 0;
    failures = 0;

    v_flat = fill(8'h00);
    x_flat = fill(EXP_FLAT);
    v_hot  = fill(8'h80);
    v_hot[7:0] = 8'd127;
    x_hot  = '0;
    x_hot[7:0] = EXP_HOT;
    v_two  = fill(8'h80);
    v_two[3*8 +: 8]  = 8'd10;
    v_two[17*8 +: 8] = 8'd10;
    x_two  = '0;
    x_two[3*8 +: 8]  = 8'd59;
    x_two[17*8 +: 8] = 8'd59;
    v_pair = fill(8'h80);
    v_pair[7:0]  = 8'd5;
    v_pair[15:8] = 8'd4;
    x_pair = '0;
    x_pair[7:0]  = 8'd64;
    x_pair[15:8] = 8'd54;

    rst                = 1'b1;
    bus.data_in_valid  = 1'b0;
    bus.in_data        = '0;
    bus.in_scale       = 16'd20132;
    bus.out_scale      = 16'd475;
    bus.S              = 6'd28;
    bus.data_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", VW'(bus.data_out_valid), VW'(0));
    check("rst_out_data", bus.out_data, '0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", VW'(bus.data_in_ready), VW'(1));

    run_one("flat", v_flat, res);
    check("flat_data", res, x_flat);
    run_one("hot", v_hot, res);
    check("hot_data", res, x_hot);
    run_one("two", v_two, res);
    check("two_data", res, x_two);
    run_one("pair", v_pair, res);
    check("pair_data", res, x_pair);
    check("pair_order", VW'(res[7:0] > res[15:8]), VW'(1));

    // Backpressure: three vectors, output stalled for four cycles
    @(negedge clk);
    bus.data_out_ready = 1'b0;
    bus.in_data        = v_flat;
    bus.data_in_valid  = 1'b1;
    @(posedge clk);
    #1 bus.in_data = v_hot;
    @(negedge clk);
    check("bp_ready_1", VW'(bus.data_in_ready), VW'(1));
    @(posedge clk);
    #1 bus.in_data = v_two;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_ready_low", VW'(bus.data_in_ready), VW'(0));
      check("bp_hold_valid", VW'(bus.data_out_valid), VW'(1));
      check("bp_hold_data", bus.out_data, x_flat);
    end
    bus.data_out_ready = 1'b1;
    @(posedge clk);
    #1 bus.data_in_valid = 1'b0;
    @(negedge clk);
    check("bp_second_valid", VW'(bus.data_out_valid), VW'(1));
    check("bp_second_data", bus.out_data, x_hot);
    @(negedge clk);
    check("bp_third_valid", VW'(bus.data_out_valid), VW'(1));
    check("bp_third_data", bus.out_data, x_two);
    @(negedge clk);
    check("bp_drained", VW'(bus.data_out_valid), VW'(0));

    // Reset with both stages holding a vector
    bus.data_out_ready = 1'b0;
    bus.in_data        = v_hot;
    bus.data_in_valid  = 1'b1;
    @(posedge clk);
    #1 bus.in_data = v_two;
    @(posedge clk);
    #1 bus.data_in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", VW'(bus.data_out_valid), VW'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_valid", VW'(bus.data_out_valid), VW'(0));
    check("mid_rst_data", bus.out_data, '0);
    @(negedge clk);
    rst = 1'b0;
    bus.data_out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_empty", VW'(bus.data_out_valid), VW'(0));
    run_one("post_rst", v_pair, res);
    check("post_rst_data", res, x_pair);
    @(negedge clk);
    check("post_rst_drained", VW'(bus.data_out_valid), VW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
